// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial two's-complement adder/subtractor. It uses one full-adder slice
//   and a carry flop. Operands are loaded in parallel, processed LSB-first at one
//   bit per clock, and the result is returned in parallel. A result appears
//   WIDTH+1 cycles after the start is accepted.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      capture a, b, sub (honoured only while busy=0)
//   sub        0: a+b, 1: a-b
//   a, b       WIDTH-bit operands
//   busy       operation in progress (RUN or DONE)
//   done       one-cycle pulse when sum/carry_out/overflow are fresh
//   sum        WIDTH-bit result, held until the next op completes
//   carry_out  carry from the MSB (for sub=1, 1 means no borrow)
//   overflow   signed overflow of the WIDTH-bit result
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RES_W = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    // Holds the low WIDTH-1 result bits. The MSB comes directly from the
    // adder on the last RUN cycle.
    logic [RES_W-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic s_bit, c_bit, last;

    // Single full-adder slice
    assign s_bit = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last  = (cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    // Subtraction is a + ~b + 1, so the +1 enters as the initial carry.
                    a_sr  <= a;
                    b_sr  <= sub ? ~b : b;
                    carry <= sub;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= c_bit;
                    res_sr <= RES_W'({s_bit, res_sr} >> 1);
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        sum       <= {s_bit, res_sr};
                        carry_out <= c_bit;
                        // Signed overflow when the carries into and out of the MSB differ.
                        overflow  <= carry ^ c_bit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
//   Directed testbench for serial_add_sub (WIDTH=8). An arithmetic reference
//   model predicts busy/done/results every cycle, and a hand-computed literal
//   check is made at each done pulse.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] sum;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {carry, overflow, sum}
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
        int ux, uy, u, sx, sy, r;
        logic v;
        ux = int'(x);
        uy = s ? ((1 << W) - 1 - int'(y)) : int'(y);
        u  = ux + uy + (s ? 1 : 0);
        sx = (ux >= (1 << (W-1))) ? ux - (1 << W) : ux;
        sy = (int'(y) >= (1 << (W-1))) ? int'(y) - (1 << W) : int'(y);
        r  = s ? sx - sy : sx + sy;
        v  = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
        return {u[W], v, u[W-1:0]};
    endfunction

    // Cycle-level model. rem counts the busy cycles that remain; done is the last one.
    int           rem = 0;
    logic [W+1:0] pend = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_c = 1'b0, m_v = 1'b0;
    bit           en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            rem = 0; m_sum = '0; m_c = 1'b0; m_v = 1'b0;
        end else if (rem == 0) begin
            if (start) begin
                rem  = W + 1;
                pend = ref_op(a, b, sub);
            end
        end else begin
            rem--;
            if (rem == 1) {m_c, m_v, m_sum} = pend;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("busy", 32'(busy), 32'(rem > 0));
            chk("done", 32'(done), 32'(rem == 1));
            chk("sum", 32'(sum), 32'(m_sum));
            chk("carry_out", 32'(carry_out), 32'(m_c));
            chk("overflow", 32'(overflow), 32'(m_v));
        end
    end

    // Start one op and wait for done. The op must take W+1 cycles and give the
    // literal results. If inj > 0, a spurious start (1+1) is pulsed on that RUN cycle.
    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic [W-1:0] e_sum, input logic e_c,
                          input logic e_v, input int inj);
        int n;
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == inj) begin a = 8'd1; b = 8'd1; sub = 1'b0; start = 1'b1; end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (!done) chk({name, "_timeout"}, 32'(done), 32'd1);
        chk({name, "_latency"}, 32'(n), 32'(W + 1));
        chk({name, "_sum"}, 32'(sum), 32'(e_sum));
        chk({name, "_cout"}, 32'(carry_out), 32'(e_c));
        chk({name, "_ovf"}, 32'(overflow), 32'(e_v));
    endtask

    initial begin
        // Reset held for two edges
        repeat (2) @(negedge clk);
        en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Pin the model itself
        chk("model_3p5", 32'(ref_op(8'd3, 8'd5, 1'b0)), 32'h008);
        chk("model_80m1", 32'(ref_op(8'h80, 8'h01, 1'b1)), 32'h37F);

        run_op("add_3_5",   8'd3,   8'd5,   1'b0, 8'd8,   1'b0, 1'b0, 0);
        run_op("wrap",      8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0, 0);
        run_op("ovf_pos",   8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1, 0);
        run_op("ovf_neg",   8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1, 0);
        run_op("borrow",    8'd5,   8'd7,   1'b1, 8'hFE,  1'b0, 1'b0, 3);
        run_op("ovf_add50", 8'h50,  8'h50,  1'b0, 8'hA0,  1'b0, 1'b1, 0);
        run_op("zero_m1",   8'h00,  8'h01,  1'b1, 8'hFF,  1'b0, 1'b0, 0);

        // Abort with reset on the 4th RUN cycle
        @(negedge clk);
        a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
        @(negedge clk);                 // RUN cycle 1
        start = 1'b0;
        repeat (2) @(negedge clk);      // RUN cycles 2, 3
        @(negedge clk);                 // RUN cycle 4
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_op("after_abort", 8'd2, 8'd2, 1'b0, 8'd4, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
